// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to packed-BCD converter.
// One shift/add-3 step per clock. With the output registers, a start
// accepted at edge N shows done and the new bcd after edge N+15, and a
// start accepted in DONE restarts with no idle cycle.
// Compile-time option: define BIN2BCD_SATURATE_EN to report over-range
// inputs as all-nines instead of all-F.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);
`ifdef BIN2BCD_SATURATE_EN
    localparam logic [4*DIGITS-1:0] OVF_CODE = {DIGITS{4'h9}};
`else
    localparam logic [4*DIGITS-1:0] OVF_CODE = {DIGITS{4'hF}};
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [BIN_W-1:0]     bin_q;
    logic [4*DIGITS-1:0]  scr_q;
    logic [4*DIGITS-1:0]  scr_adj;
    logic [3:0]           cnt_q;
    logic                 rng_q;      // captured value was out of range
    logic                 accept;
    logic                 in_rng;

    // Range test on the incoming value; latched at accept because the
    // binary register is shifted away during the conversion.
    assign in_rng = ({{(32-BIN_W){1'b0}}, bin_in} > MAX_VAL);

    // Add-3 correction for every digit that is 5 or more.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign scr_adj[4*d +: 4] = (scr_q[4*d +: 4] >= 4'd5) ? scr_q[4*d +: 4] + 4'd3
                                                              : scr_q[4*d +: 4];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a start is taken in IDLE or DONE only.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == 4'(BIN_W-1)) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, one double-dabble step per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
            rng_q <= 1'b0;
        end else if (accept) begin
            bin_q <= bin_in;
            scr_q <= '0;
            cnt_q <= '0;
            rng_q <= in_rng;
        end else if (state == SHIFT) begin
            {scr_q, bin_q} <= {scr_adj[4*DIGITS-2:0], bin_q, 1'b0};
            cnt_q          <= cnt_q + 4'd1;
        end
    end

    // Registered outputs; bcd/ovf load once per conversion and hold
    // until the next result. The scratch/flag read here are the values
    // before any same-edge restart overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
            ovf  <= 1'b0;
        end else begin
            busy <= (state == SHIFT);
            done <= (state == DONE);
            if (state == DONE) begin
                ovf <= rng_q;
                bcd <= rng_q ? OVF_CODE : scr_q;
            end
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 14: width of the binary input; fixed at 14 in this release.
REQ-002 Parameter DIGITS, default 4: number of BCD output digits; fixed at 4 in this release.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  conversion request; sampled on the rising edge of clk.
REQ-006 bin_in  input  14  unsigned binary value; sampled together with an accepted start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse marking a completed conversion.
REQ-009 bcd  output  16  four packed BCD digits, thousands in [15:12] through units in [3:0]; feeds the 16-bit digit input of the seven-segment display stage.
REQ-010 ovf  output  1  high when the last accepted bin_in exceeded 9999.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: bin_in is captured, the 16-bit BCD scratch register is cleared, the iteration counter is set to 0, and the FSM moves to SHIFT.
REQ-013 In SHIFT, each cycle SHALL perform one double-dabble step:
- add 3 to every scratch nibble that is >=5;
- then shift {scratch, binary} left by one bit.
REQ-014 SHIFT SHALL last exactly 14 cycles; the iteration counter is 4 bits, and the step with counter 13 moves the FSM to DONE.
REQ-015 On entry to DONE:
- bcd and ovf SHALL be updated in the same edge;
- done=1 for exactly one cycle.
REQ-016 Latency: if start is accepted at edge N, done and the new bcd SHALL be visible after edge N+15.
REQ-017 Throughput: a start accepted while in DONE SHALL begin the next conversion with no idle cycle, giving one result per 15 cycles.
REQ-018 busy SHALL be 1 exactly in SHIFT and 0 in IDLE and DONE.
REQ-019 start while busy=1 SHALL be ignored, and bin_in changes during SHIFT SHALL not affect the result.
REQ-020 From DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-021 bcd and ovf SHALL hold their values between done pulses.
REQ-022 ovf SHALL be computed from the captured value (>9999), and the conversion SHALL still take the full 15-cycle latency.
REQ-023 For captured values 0..9999, bcd SHALL equal the exact decimal digits and ovf SHALL be 0.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force the following:
- FSM to IDLE;
- busy, done and ovf to 0;
- bcd to 16'h0000;
- scratch, captured value and counter to 0.
REQ-025 Reset mid-conversion SHALL abort the conversion: no done pulse, bcd stays 16'h0000.
REQ-026 After rst_n rises, the first clk edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 Macro BIN2BCD_SATURATE_EN selects the out-of-range output value.
REQ-028 With BIN2BCD_SATURATE_EN defined, a value >9999 SHALL produce bcd=16'h9999 and ovf=1.
REQ-029 Without BIN2BCD_SATURATE_EN, a value >9999 SHALL produce bcd=16'hFFFF (the display shows "FFFF") and ovf=1.
REQ-030 In-range behaviour SHALL be identical with or without the macro.

Verification
REQ-031 Reset, then start with bin_in=1234 at edge N:
- busy=1 after edges N+1..N+14;
- done=1 and bcd=16'h1234 after edge N+15;
- done=0 after edge N+16.
REQ-032 Boundary values:
- bin_in=0 -> bcd=16'h0000, ovf=0;
- bin_in=9999 -> bcd=16'h9999, ovf=0;
- bin_in=10 -> bcd=16'h0010.
REQ-033 Over-range: bin_in=10000, and separately 16383:
- with BIN2BCD_SATURATE_EN -> bcd=16'h9999, ovf=1;
- without the macro -> bcd=16'hFFFF, ovf=1.
REQ-034 Start with 4321, then pulse start with bin_in=5555 at N+5 -> result 16'h4321 at N+15, second request ignored, no extra done.
REQ-035 Back-to-back: start held high with 100, then 200 presented in the done cycle:
- done pulses at N+15 and N+30;
- bcd=16'h0100, then 16'h0200.
REQ-036 Reset: rst_n=0 at N+7 of a conversion of 777 -> outputs zero immediately, no done; after release, a new start with 42 -> bcd=16'h0042 after 15 edges.
